// File: rtl/vga_pkg.sv
// Shared VGA raster types and default 640x480@60 timing, also used by the image/sprite renderers.
package vga_pkg;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {ACT, FP, SY, BP} sync_state_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;
    localparam int COORD_RANGE  = 1024;

    function automatic sync_state_t axis_state(coord_t pos, coord_t fp_start,
                                               coord_t sy_start, coord_t bp_start);
        if (pos < fp_start)
            return ACT;
        else if (pos < sy_start)
            return FP;
        else if (pos < bp_start)
            return SY;
        return BP;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with a registered porch/sync phase.
// state | meaning
// ACT   | visible region
// FP    | front porch
// SY    | sync pulse
// BP    | back porch
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FRONT  = H_FRONT_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BACK   = H_BACK_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_step,
    output logic [9:0] o_pos,
    output logic [1:0] o_state_nxt,
    output logic       o_wrap
);

    localparam int     TOTAL    = ACTIVE + FRONT + SYNC + BACK;
    localparam coord_t LAST     = coord_t'(TOTAL - 1);
    localparam coord_t FP_START = coord_t'(ACTIVE);
    localparam coord_t SY_START = coord_t'(ACTIVE + FRONT);
    localparam coord_t BP_START = coord_t'(ACTIVE + FRONT + SYNC);

    generate
        if (TOTAL > COORD_RANGE) begin : g_total_chk
            $error("vga_axis_counter: axis total %0d does not fit 10 bits", TOTAL);
        end
    endgenerate

    coord_t      r_pos;
    coord_t      w_pos_nxt;
    sync_state_t r_state;
    sync_state_t w_state_nxt;
    logic        w_wrap;

    assign w_wrap      = (r_pos == LAST);
    assign o_pos       = r_pos;
    assign o_wrap      = w_wrap;
    assign o_state_nxt = w_state_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pos   <= '0;
            r_state <= ACT;
        end else begin
            r_pos   <= w_pos_nxt;
            r_state <= w_state_nxt;
        end
    end

    // Phase is decoded from the position being loaded so it lands with that position.
    always_comb begin
        w_pos_nxt   = r_pos;
        w_state_nxt = r_state;
        if (i_step) begin
            w_pos_nxt   = w_wrap ? '0 : r_pos + coord_t'(1);
            w_state_nxt = axis_state(w_pos_nxt, FP_START, SY_START, BP_START);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: H/V axis counters, registered sync/blank aligned to DrawX/DrawY,
// line/frame strobes and a completed-frame counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FRONT  = H_FRONT_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BACK   = H_BACK_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FRONT  = V_FRONT_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BACK   = V_BACK_DEF,
    parameter logic SYNC_POL = 1'b0,
    parameter int   FCNT_W   = 8
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              pix_en,
    output logic              hs,
    output logic              vs,
    output logic              blank,
    output logic [9:0]        DrawX,
    output logic [9:0]        DrawY,
    output logic              line_start,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_count
);

    localparam logic [FCNT_W-1:0] FCNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

    logic              r_run;
    logic              r_hs;
    logic              r_vs;
    logic              r_blank;
    logic              r_line_start;
    logic              r_frame_start;
    logic [FCNT_W-1:0] r_frame_count;

    logic       w_h_step;
    logic       w_v_step;
    logic       w_h_wrap;
    logic       w_v_wrap;
    logic [1:0] w_h_state_nxt;
    logic [1:0] w_v_state_nxt;
    logic [9:0] w_h_pos;
    logic [9:0] w_v_pos;

    // The first enabled edge after reset presents (0,0) itself; stepping starts after that.
    assign w_h_step = pix_en & r_run;
    assign w_v_step = w_h_step & w_h_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_axis (
        .i_clk       (vga_clk),
        .i_rst       (reset),
        .i_step      (w_h_step),
        .o_pos       (w_h_pos),
        .o_state_nxt (w_h_state_nxt),
        .o_wrap      (w_h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_axis (
        .i_clk       (vga_clk),
        .i_rst       (reset),
        .i_step      (w_v_step),
        .o_pos       (w_v_pos),
        .o_state_nxt (w_v_state_nxt),
        .o_wrap      (w_v_wrap)
    );

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_run         <= 1'b0;
            r_hs          <= ~SYNC_POL;
            r_vs          <= ~SYNC_POL;
            r_blank       <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_hs          <= (sync_state_t'(w_h_state_nxt) == SY) ? SYNC_POL : ~SYNC_POL;
            r_vs          <= (sync_state_t'(w_v_state_nxt) == SY) ? SYNC_POL : ~SYNC_POL;
            r_blank       <= (sync_state_t'(w_h_state_nxt) == ACT) &&
                             (sync_state_t'(w_v_state_nxt) == ACT);
            r_line_start  <= pix_en & (~r_run | w_h_wrap);
            r_frame_start <= pix_en & (~r_run | (w_h_wrap & w_v_wrap));
            if (pix_en)
                r_run <= 1'b1;
            if (w_v_step & w_v_wrap)
                r_frame_count <= r_frame_count + FCNT_ONE;
        end
    end

    assign hs          = r_hs;
    assign vs          = r_vs;
    assign blank       = r_blank;
    assign DrawX       = w_h_pos;
    assign DrawY       = w_v_pos;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing for the sprite and image renderers: horizontal and vertical sync, DrawX/DrawY pixel coordinates, and the active-video flag `blank`.
- Renderers consume DrawX/DrawY/blank on the same `vga_clk`. They issue ROM reads on the falling edge and register pixels on the rising edge, so coordinates must be glitch-free registered outputs.
- Also emits line/frame strobes and a frame counter, used by animation logic such as the beat-step highlight.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low hs/vs)
- FCNT_W, 8, frame counter width

Ports:
- vga_clk  in  1  pixel clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel advance enable; tie 1 for one pixel per clock
- hs  out  1  horizontal sync, level per SYNC_POL
- vs  out  1  vertical sync, level per SYNC_POL
- blank  out  1  1 = active video (renderer drives colour), 0 = blanking
- DrawX  out  10  horizontal counter, 0..H_TOTAL-1
- DrawY  out  10  vertical counter, 0..V_TOTAL-1
- line_start  out  1  one-clock pulse when DrawX wraps to 0
- frame_start  out  1  one-clock pulse when DrawX and DrawY both wrap to 0
- frame_count  out  FCNT_W  completed-frame counter

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525). Counters are 10 bits; elaboration fails if either total exceeds 1024.
- Reset (asynchronous, immediate on assertion):
  - DrawX = 0, DrawY = 0, blank = 1, frame_count = 0
  - hs and vs deasserted (= ~SYNC_POL)
  - line_start = 0, frame_start = 0
  - First pixel (0,0) is presented on the first enabled edge after reset release.
- Horizontal FSM, states H_ACT, H_FP, H_SY, H_BP, decoded from DrawX:
  - H_ACT: DrawX < H_ACTIVE
  - H_FP: DrawX < H_ACTIVE + H_FRONT
  - H_SY: DrawX < H_ACTIVE + H_FRONT + H_SYNC
  - H_BP: otherwise
  - The state is held in a registered field, not recomputed combinationally at the outputs.
- Vertical FSM V_ACT/V_FP/V_SY/V_BP uses the identical scheme on DrawY. It advances only on the clock where DrawX wraps.
- On each rising edge with pix_en = 1:
  - DrawX increments. At H_TOTAL-1 it wraps to 0, and DrawY increments (DrawY wraps at V_TOTAL-1).
- Output alignment: hs, vs and blank are registered and aligned with the DrawX/DrawY values of the same cycle. There is no extra pipeline skew: the outputs describe the pixel currently presented.
  - blank = (H state == H_ACT) && (V state == V_ACT)
  - hs = SYNC_POL while H state == H_SY
  - vs = SYNC_POL while V state == V_SY. vs changes on the same edge DrawX wraps to 0.
- Strobes:
  - line_start = 1 for exactly the cycle in which DrawX == 0 was first presented.
  - frame_start additionally requires DrawY == 0.
  - Both strobes are 0 whenever pix_en = 0 or DrawX is held.
- frame_count increments on the edge where DrawY wraps from V_TOTAL-1 to 0. It wraps modulo 2^FCNT_W with no saturation.
- pix_en = 0: all counters, states and syncs hold; strobes forced to 0.
- Reset asserted mid-line or mid-frame: immediate return to the reset values; no partial sync pulse is stretched.
- Simultaneous H and V wrap (last pixel of the frame): on one edge DrawX = 0, DrawY = 0, line_start = 1, frame_start = 1, and frame_count increments.

Decomposition:
- Shared package vga_pkg holds:
  - typedef enum for the sync state (ACT, FP, SY, BP)
  - default 640x480@60 timing constants
  - the 10-bit coordinate typedef, shared with the image/sprite renderers
- One sub-module, vga_axis_counter: counter plus 4-state FSM, parameterised by ACTIVE/FRONT/SYNC/BACK, with inputs step and outputs pos, state and wrap. Instantiated twice: the H instance is stepped by pix_en; the V instance is stepped by H wrap & pix_en.

Test Plan:
- Reset release, pix_en = 1, run 800 clocks -> hs low exactly for DrawX 656..751; blank = 1 for DrawX 0..639; line_start pulses at clocks 0 and 800.
- Run one full frame (420000 clocks) -> vs low exactly during DrawY 490..491; blank = 0 for all DrawY >= 480; frame_start pulses once; frame_count 0 -> 1.
- Toggle pix_en at 50% (1,0,1,0...) -> line period 1600 clocks; counters hold on 0-cycles; strobes never high while pix_en = 0.
- Last pixel (799,524) -> next edge gives DrawX = 0, DrawY = 0, line_start = 1, frame_start = 1, frame_count increments; FCNT_W = 8 wraps 255 -> 0 after 256 frames.
- Assert reset mid-sync (DrawX = 700, DrawY = 491) -> hs, vs go high immediately without waiting for a clock; DrawX = 0, DrawY = 0, frame_count = 0.
- SYNC_POL = 1 build with reduced timing (H 8/2/2/2, V 4/1/1/1) -> positive sync pulses of 2 clocks per line and 1 line per frame; period 14 x 7 clocks.
